// File: rtl/muldiv_unit.sv
// Purpose: iterative RV32M-style multiply/divide unit (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU), XLEN-generic.
// Latency: done in cycle XLEN+1 after the accept edge; divide-by-zero and signed overflow finish in cycle 1.
// Backpressure: one op at a time; start is only sampled in IDLE, busy stalls the pipe, kill aborts silently.
module muldiv_unit #(
  parameter int XLEN = 32,
  parameter int RD_W = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  logic [RD_W-1:0] rd_in,
  input  logic            kill,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic [RD_W-1:0] rd_out
);

  localparam int CNT_W = (XLEN > 1) ? $clog2(XLEN) : 1;
  localparam logic [XLEN-1:0] MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0] ALL_ONES = {XLEN{1'b1}};

  localparam logic [2:0] F_MUL    = 3'b000;
  localparam logic [2:0] F_MULH   = 3'b001;
  localparam logic [2:0] F_MULHSU = 3'b010;
  localparam logic [2:0] F_MULHU  = 3'b011;
  localparam logic [2:0] F_DIV    = 3'b100;
  localparam logic [2:0] F_DIVU   = 3'b101;
  localparam logic [2:0] F_REM    = 3'b110;
  localparam logic [2:0] F_REMU   = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_FIN  = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [2:0]        f3_q, f3_d;
  logic              neg_q, neg_d;
  logic [XLEN-1:0]   mcand_q, mcand_d;
  // Shared accumulator: multiply keeps {product_hi, multiplier/product_lo},
  // divide keeps {partial remainder, dividend/quotient}.
  logic [2*XLEN-1:0] prod_q, prod_d;
  logic [RD_W-1:0]   rd_q, rd_d;
  logic [XLEN-1:0]   result_q, result_d;
  logic [RD_W-1:0]   rd_out_q, rd_out_d;

  // Operand decode, computed from the raw inputs so it is ready at the accept edge.
  logic            accept;
  logic            is_div;
  logic            a_signed, b_signed;
  logic            a_neg, b_neg;
  logic [XLEN-1:0] a_mag, b_mag;
  logic            div_zero, div_ovf, fast;
  logic [XLEN-1:0] fast_val;
  logic            neg_start;

  // Iteration datapath
  logic              iter_en, cnt_last;
  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] mul_next;
  logic [XLEN:0]     div_tmp, div_diff;
  logic              div_ge;
  logic [2*XLEN-1:0] div_next;

  // Fix-up stage
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quo_fix, rem_fix;
  logic [XLEN-1:0]   fin_res;

  // Decode signedness, magnitudes and the divide special cases of the incoming op.
  always_comb begin
    accept   = (state_q == S_IDLE) && start && !kill;
    is_div   = funct3[2];
    if (is_div) begin
      a_signed = ~funct3[0];
      b_signed = ~funct3[0];
    end else begin
      a_signed = (funct3 != F_MULHU);
      b_signed = (funct3 == F_MUL) || (funct3 == F_MULH);
    end
    a_neg    = a_signed & op_a[XLEN-1];
    b_neg    = b_signed & op_b[XLEN-1];
    a_mag    = a_neg ? (~op_a + 1'b1) : op_a;
    b_mag    = b_neg ? (~op_b + 1'b1) : op_b;
    div_zero = (op_b == '0);
    div_ovf  = ~funct3[0] && (op_a == MIN_NEG) && (op_b == ALL_ONES);
    fast     = is_div && (div_zero || div_ovf);
    // REM/REMU have funct3[1] set; DIV/DIVU clear.
    if (div_zero) begin
      fast_val = funct3[1] ? op_a : ALL_ONES;
    end else begin
      fast_val = funct3[1] ? '0 : op_a;
    end
    // Remainder follows the dividend's sign; product and quotient follow the XOR.
    if (is_div && funct3[1]) begin
      neg_start = a_neg;
    end else begin
      neg_start = a_neg ^ b_neg;
    end
  end

  // One shift-add multiply step and one restoring divide step on the accumulator.
  always_comb begin
    iter_en  = ((state_q == S_MUL) || (state_q == S_DIV)) && !kill;
    cnt_last = (cnt_q == CNT_W'(XLEN - 1));
    mul_sum  = {1'b0, prod_q[2*XLEN-1:XLEN]} + (prod_q[0] ? {1'b0, mcand_q} : '0);
    mul_next = {mul_sum, prod_q[XLEN-1:1]};
    div_tmp  = {prod_q[2*XLEN-1:XLEN], prod_q[XLEN-1]};
    div_diff = div_tmp - {1'b0, mcand_q};
    // Partial remainder stays below the divisor, so the difference sign bit is exact.
    div_ge   = ~div_diff[XLEN];
    if (div_ge) begin
      div_next = {div_diff[XLEN-1:0], prod_q[XLEN-2:0], 1'b1};
    end else begin
      div_next = {div_tmp[XLEN-1:0], prod_q[XLEN-2:0], 1'b0};
    end
  end

  // Sign fix-up and result select used during the FIN cycle.
  always_comb begin
    prod_fix = neg_q ? (~prod_q + 1'b1) : prod_q;
    quo_fix  = neg_q ? (~prod_q[XLEN-1:0] + 1'b1) : prod_q[XLEN-1:0];
    rem_fix  = neg_q ? (~prod_q[2*XLEN-1:XLEN] + 1'b1) : prod_q[2*XLEN-1:XLEN];
    fin_res  = '0;
    case (f3_q)
      F_MUL:                       fin_res = prod_fix[XLEN-1:0];
      F_MULH, F_MULHSU, F_MULHU:   fin_res = prod_fix[2*XLEN-1:XLEN];
      F_DIV, F_DIVU:               fin_res = quo_fix;
      F_REM, F_REMU:               fin_res = rem_fix;
      default:                     fin_res = '0;
    endcase
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_d = state_q;
    busy    = (state_q != S_IDLE);
    done    = (state_q == S_FIN) && !kill;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (fast) begin
            state_d = S_FIN;
          end else if (is_div) begin
            state_d = S_DIV;
          end else begin
            state_d = S_MUL;
          end
        end
      end
      S_MUL, S_DIV: begin
        if (kill) begin
          state_d = S_IDLE;
        end else if (cnt_last) begin
          state_d = S_FIN;
        end
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath next-state: load on accept, step while iterating, publish on done.
  always_comb begin
    cnt_d    = cnt_q;
    f3_d     = f3_q;
    neg_d    = neg_q;
    mcand_d  = mcand_q;
    prod_d   = prod_q;
    rd_d     = rd_q;
    result_d = result_q;
    rd_out_d = rd_out_q;
    if (accept) begin
      cnt_d = '0;
      f3_d  = funct3;
      rd_d  = rd_in;
      if (fast) begin
        // Both halves hold the answer so FIN picks it for either quotient or remainder.
        neg_d   = 1'b0;
        mcand_d = '0;
        prod_d  = {fast_val, fast_val};
      end else if (is_div) begin
        neg_d   = neg_start;
        mcand_d = b_mag;
        prod_d  = {{XLEN{1'b0}}, a_mag};
      end else begin
        neg_d   = neg_start;
        mcand_d = a_mag;
        prod_d  = {{XLEN{1'b0}}, b_mag};
      end
    end else if (iter_en) begin
      cnt_d  = cnt_q + CNT_W'(1);
      prod_d = (state_q == S_MUL) ? mul_next : div_next;
    end
    if (done) begin
      result_d = fin_res;
      rd_out_d = rd_q;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath and result registers; reset clears everything so an aborted op leaves no trace.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q    <= '0;
      f3_q     <= '0;
      neg_q    <= 1'b0;
      mcand_q  <= '0;
      prod_q   <= '0;
      rd_q     <= '0;
      result_q <= '0;
      rd_out_q <= '0;
    end else begin
      cnt_q    <= cnt_d;
      f3_q     <= f3_d;
      neg_q    <= neg_d;
      mcand_q  <= mcand_d;
      prod_q   <= prod_d;
      rd_q     <= rd_d;
      result_q <= result_d;
      rd_out_q <= rd_out_d;
    end
  end

  // Present the fresh result in the done cycle, then hold it from the register.
  always_comb begin
    result = done ? fin_res : result_q;
    rd_out = done ? rd_q : rd_out_q;
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit: table of RV32M vectors plus kill / reset / held-start sequences.
// Expected results are queued at acceptance and compared when done pulses.
// Latency and busy duration are counted per op against the XLEN+1 / fast-path figures.
module tb_muldiv_unit;

  localparam int XLEN = 32;
  localparam int RD_W = 5;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            start = 1'b0;
  logic [2:0]      funct3 = 3'b000;
  logic [XLEN-1:0] op_a = '0;
  logic [XLEN-1:0] op_b = '0;
  logic [RD_W-1:0] rd_in = '0;
  logic            kill = 1'b0;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] result;
  logic [RD_W-1:0] rd_out;

  muldiv_unit #(.XLEN(XLEN), .RD_W(RD_W)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .funct3 (funct3),
    .op_a   (op_a),
    .op_b   (op_b),
    .rd_in  (rd_in),
    .kill   (kill),
    .busy   (busy),
    .done   (done),
    .result (result),
    .rd_out (rd_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]      f3;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic [RD_W-1:0] rd;
    logic [XLEN-1:0] exp;
    bit              fast;
  } vec_t;

  typedef struct {
    logic [XLEN-1:0] res;
    logic [RD_W-1:0] rd;
  } exp_t;

  exp_t sb_q[$];
  vec_t vecs[20];
  int   total = 0;
  int   bad = 0;
  logic prev_done = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Scoreboard: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    exp_t e;
    if (done === 1'b1) begin
      check("done_not_consecutive", {31'b0, prev_done}, 32'd0);
      if (sb_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL spurious_done: got done=1 with result %h expected no pending op", result);
      end else begin
        e = sb_q.pop_front();
        check("result", result, e.res);
        check("rd_out", {27'b0, rd_out}, {27'b0, e.rd});
      end
    end
    prev_done = done;
  end

  task automatic run_op(input vec_t v, input bit hold);
    int lat;
    int busy_n;
    lat = 0;
    busy_n = 0;
    funct3 = v.f3;
    op_a = v.a;
    op_b = v.b;
    rd_in = v.rd;
    start = 1'b1;
    @(posedge clk);
    sb_q.push_back('{v.exp, v.rd});
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (!hold) start = 1'b0;
      // Scramble inputs: the unit must not resample them mid-op.
      op_a = $urandom;
      op_b = $urandom;
      funct3 = 3'($urandom_range(0, 7));
      rd_in = 5'($urandom_range(0, 31));
      if (busy === 1'b1) busy_n++;
      if (done === 1'b1) begin
        lat = c;
        break;
      end
    end
    start = 1'b0;
    if (lat == 0) begin
      total++;
      bad++;
      $display("FAIL timeout: got no done within 40 cycles expected done for f3=%0d", v.f3);
      sb_q.delete();
    end
    check("latency", lat, v.fast ? 32'd1 : 32'(XLEN + 1));
    check("busy_cycles", busy_n, v.fast ? 32'd1 : 32'(XLEN + 1));
    @(negedge clk);
    check("busy_after_done", {31'b0, busy}, 32'd0);
    check("result_hold", result, v.exp);
  endtask

  initial begin
    #200us;
    $display("FAIL watchdog: got no finish expected finish before 200us");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    logic [XLEN-1:0] last_res;
    logic [RD_W-1:0] last_rd;

    vecs[0]  = '{3'b000, 32'd7,        32'hFFFFFFFD, 5'd5,  32'hFFFFFFEB, 1'b0};
    vecs[1]  = '{3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd1,  32'hFFFFFFFE, 1'b0};
    vecs[2]  = '{3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd2,  32'h00000000, 1'b0};
    vecs[3]  = '{3'b010, 32'hFFFFFFFF, 32'd2,        5'd3,  32'hFFFFFFFF, 1'b0};
    vecs[4]  = '{3'b100, 32'hFFFFFFF9, 32'd2,        5'd4,  32'hFFFFFFFD, 1'b0};
    vecs[5]  = '{3'b110, 32'hFFFFFFF9, 32'd2,        5'd6,  32'hFFFFFFFF, 1'b0};
    vecs[6]  = '{3'b101, 32'd100,      32'd7,        5'd7,  32'd14,       1'b0};
    vecs[7]  = '{3'b111, 32'd100,      32'd7,        5'd8,  32'd2,        1'b0};
    vecs[8]  = '{3'b101, 32'd5,        32'd0,        5'd9,  32'hFFFFFFFF, 1'b1};
    vecs[9]  = '{3'b110, 32'd5,        32'd0,        5'd10, 32'd5,        1'b1};
    vecs[10] = '{3'b100, 32'h80000000, 32'hFFFFFFFF, 5'd11, 32'h80000000, 1'b1};
    vecs[11] = '{3'b110, 32'h80000000, 32'hFFFFFFFF, 5'd12, 32'h00000000, 1'b1};
    vecs[12] = '{3'b001, 32'h80000000, 32'h80000000, 5'd13, 32'h40000000, 1'b0};
    vecs[13] = '{3'b011, 32'h80000000, 32'd2,        5'd14, 32'h00000001, 1'b0};
    vecs[14] = '{3'b100, 32'h80000000, 32'd2,        5'd15, 32'hC0000000, 1'b0};
    vecs[15] = '{3'b100, 32'd7,        32'hFFFFFFFE, 5'd16, 32'hFFFFFFFD, 1'b0};
    vecs[16] = '{3'b110, 32'd7,        32'hFFFFFFFE, 5'd17, 32'd1,        1'b0};
    vecs[17] = '{3'b101, 32'hFFFFFFFF, 32'd10,       5'd18, 32'h19999999, 1'b0};
    vecs[18] = '{3'b111, 32'hFFFFFFFF, 32'd10,       5'd19, 32'd5,        1'b0};
    vecs[19] = '{3'b010, 32'h80000000, 32'hFFFFFFFF, 5'd20, 32'h80000000, 1'b0};

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_done", {31'b0, done}, 32'd0);
    check("rst_result", result, 32'd0);
    check("rst_rd_out", {27'b0, rd_out}, 32'd0);
    rst = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 20; i++) begin
      run_op(vecs[i], 1'b0);
    end
    last_res = vecs[19].exp;
    last_rd  = vecs[19].rd;

    // Kill in cycle 10 of a DIV: no done, busy drops, previous result kept.
    funct3 = 3'b100; op_a = 32'd100; op_b = 32'd7; rd_in = 5'd21; start = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (c == 10) begin
        check("kill_busy_before", {31'b0, busy}, 32'd1);
        kill = 1'b1;
      end
    end
    @(negedge clk);
    kill = 1'b0;
    check("kill_busy_after", {31'b0, busy}, 32'd0);
    repeat (40) @(negedge clk);
    check("kill_result_kept", result, last_res);
    check("kill_rd_kept", {27'b0, rd_out}, {27'b0, last_rd});

    // start and kill together in IDLE: nothing accepted.
    funct3 = 3'b000; op_a = 32'd3; op_b = 32'd3; rd_in = 5'd22; start = 1'b1; kill = 1'b1;
    @(negedge clk);
    start = 1'b0; kill = 1'b0;
    check("idle_kill_busy", {31'b0, busy}, 32'd0);
    repeat (40) @(negedge clk);
    check("idle_kill_result", result, last_res);

    // Asynchronous reset mid-MUL clears outputs immediately.
    funct3 = 3'b000; op_a = 32'h1234; op_b = 32'h5678; rd_in = 5'd23; start = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      start = 1'b0;
    end
    #1 rst = 1'b0;
    #1;
    check("arst_busy", {31'b0, busy}, 32'd0);
    check("arst_done", {31'b0, done}, 32'd0);
    check("arst_result", result, 32'd0);
    check("arst_rd_out", {27'b0, rd_out}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // MUL 3x4 with start held high throughout the op.
    v = '{3'b000, 32'd3, 32'd4, 5'd7, 32'd12, 1'b0};
    run_op(v, 1'b1);

    repeat (5) @(negedge clk);
    check("scoreboard_empty", sb_q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
